// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths, defaults and fetch-queue entry type
package fetch_pkg;
  localparam int INSTR_W = 32;
  localparam int PC_INC = 4;
  localparam int DEF_XLEN = 32;
  localparam logic [DEF_XLEN-1:0] DEF_RESET_PC = 32'h0000_0000;

  // Entries are sized by the default XLEN; the top keeps XLEN at this value.
  typedef struct packed {
    logic [INSTR_W-1:0]  instr;
    logic [DEF_XLEN-1:0] pc;
    logic [DEF_XLEN-1:0] pcPlus4;
  } fq_entry_t;

  localparam int ENTRY_W = $bits(fq_entry_t);
endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - fetch queue: synchronous FIFO of fq_entry_t with flush and count
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [ENTRY_W-1:0]       pushData,
  input  logic                     pop,
  output logic [ENTRY_W-1:0]       headData,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  fq_entry_t      mem [DEPTH];
  logic [AW-1:0]  wrPtr, rdPtr;
  logic [AW:0]    cnt;
  logic           wrEn, rdEn;

  assign wrEn = push && (cnt != (AW+1)'(DEPTH));
  assign rdEn = pop && (cnt != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      cnt   <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      cnt   <= '0;
    end else begin
      if (wrEn) wrPtr <= wrPtr + AW'(1);
      if (rdEn) rdPtr <= rdPtr + AW'(1);
      cnt <= cnt + (AW+1)'(wrEn) - (AW+1)'(rdEn);
    end
  end

  // Storage needs no reset: only entries below cnt are ever presented.
  always_ff @(posedge clk) begin
    if (wrEn && !flush) mem[wrPtr] <= pushData;
  end

  assign headData = mem[rdPtr];
  assign count    = cnt;
endmodule

// File: rtl/fetch_stage_q.sv
// rtl/fetch_stage_q.sv - decoupled fetch stage: PC, imem credits, redirect/drop, queue to decode
module fetch_stage_q
  import fetch_pkg::*;
#(
  parameter int XLEN = DEF_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = DEF_RESET_PC,
  parameter int FQ_DEPTH = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [XLEN-1:0]    imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               dec_valid,
  input  logic               dec_ready,
  output logic [INSTR_W-1:0] dec_instr,
  output logic [XLEN-1:0]    dec_pc,
  output logic [XLEN-1:0]    dec_pc_plus4
);
  localparam int CW = $clog2(FQ_DEPTH) + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  logic [XLEN-1:0]    pcF, rspPc;
  logic [OW-1:0]      outstanding, dropCnt;
  logic [CW-1:0]      fqCount;
  logic [ENTRY_W-1:0] headBits;
  fq_entry_t          pushEntry, headEntry;
  logic               creditOk, accept, rspEvent, doPush, doPop, hasEntry;

  // Counting queued plus in-flight entries guarantees every response has a slot.
  assign creditOk = (int'(outstanding) < MAX_OUTSTANDING) &&
                    ((int'(outstanding) + int'(fqCount)) < FQ_DEPTH);
  assign imem_req_valid = rst && !redirect_valid && creditOk;
  assign imem_req_addr  = pcF;
  assign accept         = imem_req_valid && imem_req_ready;

  assign rspEvent = imem_rsp_valid && (outstanding != '0);
  assign doPush   = rspEvent && (dropCnt == '0) && !redirect_valid;

  assign hasEntry = (fqCount != '0);
  assign doPop    = hasEntry && dec_ready && !redirect_valid;

  assign pushEntry.instr   = imem_rsp_data;
  assign pushEntry.pc      = rspPc;
  assign pushEntry.pcPlus4 = rspPc + XLEN'(PC_INC);

  fetch_fifo #(.DEPTH(FQ_DEPTH)) uFifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (redirect_valid),
    .push     (doPush),
    .pushData (pushEntry),
    .pop      (doPop),
    .headData (headBits),
    .count    (fqCount)
  );

  assign headEntry    = headBits;
  assign dec_valid    = hasEntry;
  assign dec_instr    = hasEntry ? headEntry.instr   : '0;
  assign dec_pc       = hasEntry ? headEntry.pc      : '0;
  assign dec_pc_plus4 = hasEntry ? headEntry.pcPlus4 : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcF         <= RESET_PC;
      rspPc       <= RESET_PC;
      outstanding <= '0;
      dropCnt     <= '0;
    end else begin
      if (redirect_valid) begin
        pcF     <= redirect_pc;
        rspPc   <= redirect_pc;
        // A response landing in the redirect cycle is already consumed here.
        dropCnt <= outstanding - OW'(rspEvent);
      end else begin
        if (accept) pcF <= pcF + XLEN'(PC_INC);
        if (doPush) rspPc <= rspPc + XLEN'(PC_INC);
        if (rspEvent && (dropCnt != '0)) dropCnt <= dropCnt - OW'(1);
      end
      outstanding <= outstanding + OW'(accept) - OW'(rspEvent);
    end
  end
endmodule
